cnt_bcd_down_fsm: RTL and testbench

Loadable multi-digit BCD down-counter built as a Moore FSM; the count-down counterpart of the team's BCD up-counter.
- Takes a preset value in BCD, decrements once per enabled cycle, and signals terminal count with a one-cycle done pulse.
- Used as a countdown/timeout timer feeding the lab display and sequencing logic.

---
 rtl/cnt_bcd_down_fsm_pkg.sv | 24 ++
 rtl/cnt_bcd_down_fsm_bcd_digit_dec.sv | 27 ++
 rtl/cnt_bcd_down_fsm.sv | 104 ++++++++++
 tb/tb_cnt_bcd_down_fsm.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnt_bcd_down_fsm_pkg.sv
// Shared definitions for the BCD down-counter: state encoding, digit geometry
// and the preset sanitising helper.
package cnt_bcd_down_fsm_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX_DIGIT = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic [DIGIT_W-1:0] sanitise_digit(input logic [DIGIT_W-1:0] d);
    logic [DIGIT_W-1:0] r;
    if (d > BCD_MAX_DIGIT) begin
      r = BCD_MAX_DIGIT;
    end else begin
      r = d;
    end
    return r;
  endfunction

endpackage

// File: rtl/cnt_bcd_down_fsm_bcd_digit_dec.sv
// One-digit BCD decrementer with borrow chain; purely combinational.
module bcd_digit_dec
  import cnt_bcd_down_fsm_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_i,
  input  logic               borrow_i,
  output logic [DIGIT_W-1:0] digit_o,
  output logic               borrow_o
);

  // A borrow into a zero digit wraps it to nine and passes the borrow on.
  always_comb begin
    digit_o  = digit_i;
    borrow_o = 1'b0;
    if (!borrow_i) begin
      digit_o  = digit_i;
      borrow_o = 1'b0;
    end else if (digit_i == 4'd0) begin
      digit_o  = BCD_MAX_DIGIT;
      borrow_o = 1'b1;
    end else begin
      digit_o  = digit_i - 4'd1;
      borrow_o = 1'b0;
    end
  end

endmodule

// File: rtl/cnt_bcd_down_fsm.sv
// Loadable NDIG-digit BCD down-counter, Moore FSM with a one-cycle done pulse
// when the count reaches zero.
module cnt_bcd_down_fsm
  import cnt_bcd_down_fsm_pkg::*;
#(
  parameter int NDIG = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load,
  input  logic                    en,
  input  logic [DIGIT_W*NDIG-1:0] din,
  output logic [DIGIT_W*NDIG-1:0] Q,
  output logic                    busy,
  output logic                    done
);

  localparam int W = DIGIT_W * NDIG;
  localparam logic [W-1:0] ZERO_VAL = {W{1'b0}};
  localparam logic [W-1:0] ONE_VAL  = {{(W-1){1'b0}}, 1'b1};

  state_e         state_q, state_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [W-1:0]   load_val_s;
  logic [W-1:0]   dec_val_s;
  logic [NDIG:0]  borrow_s;

  assign borrow_s[0] = 1'b1;

  for (genvar g = 0; g < NDIG; g++) begin : g_digit
    assign load_val_s[g*DIGIT_W +: DIGIT_W] = sanitise_digit(din[g*DIGIT_W +: DIGIT_W]);

    bcd_digit_dec u_dec (
      .digit_i  (cnt_q[g*DIGIT_W +: DIGIT_W]),
      .borrow_i (borrow_s[g]),
      .digit_o  (dec_val_s[g*DIGIT_W +: DIGIT_W]),
      .borrow_o (borrow_s[g+1])
    );
  end

  // Next-state and next-count; load always wins over en.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (load) begin
          cnt_d   = load_val_s;
          state_d = (load_val_s == ZERO_VAL) ? ST_DONE : ST_COUNT;
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      ST_COUNT: begin
        if (load) begin
          cnt_d   = load_val_s;
          state_d = (load_val_s == ZERO_VAL) ? ST_DONE : ST_COUNT;
        end else if (en) begin
          // A borrow out of the top digit means the count is already zero:
          // finish rather than wrap to all nines.
          if (borrow_s[NDIG]) begin
            state_d = ST_DONE;
          end else begin
            cnt_d   = dec_val_s;
            state_d = (cnt_q == ONE_VAL) ? ST_DONE : ST_COUNT;
          end
        end else begin
          state_d = state_q;
          cnt_d   = cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = ZERO_VAL;
      end
    endcase
    busy_d = (state_d == ST_COUNT);
    done_d = (state_d == ST_DONE);
  end

  // State, count and decoded outputs are all registered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= ZERO_VAL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Q    = cnt_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_cnt_bcd_down_fsm.sv
// Self-checking bench: decimal-arithmetic reference model, directed scenarios
// and randomized load/enable traffic, plus a 3-digit instance.
module tb_cnt_bcd_down_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0, en = 1'b0;
  logic [7:0]  din = 8'h00;
  logic [7:0]  q;
  logic        busy, done;
  logic        load3 = 1'b0, en3 = 1'b0;
  logic [11:0] din3 = 12'h000;
  logic [11:0] q3;
  logic        busy3, done3;

  int checks = 0;
  int errors = 0;

  // reference model state: decimal count plus status flags
  int m_val  = 0;
  bit m_busy = 1'b0;
  bit m_done = 1'b0;

  always #5 clk = ~clk;

  cnt_bcd_down_fsm #(.NDIG(2)) dut (
    .clock(clk), .reset(reset), .load(load), .en(en), .din(din),
    .Q(q), .busy(busy), .done(done)
  );

  cnt_bcd_down_fsm #(.NDIG(3)) dut3 (
    .clock(clk), .reset(reset), .load(load3), .en(en3), .din(din3),
    .Q(q3), .busy(busy3), .done(done3)
  );

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    x = v;
    r = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int san_val(input logic [15:0] d, input int nd);
    int v;
    int w;
    int dig;
    v = 0;
    w = 1;
    for (int i = 0; i < nd; i++) begin
      dig = int'(d[4*i +: 4]);
      if (dig > 9) dig = 9;
      v = v + dig * w;
      w = w * 10;
    end
    return v;
  endfunction

  task automatic model_reset();
    m_val  = 0;
    m_busy = 1'b0;
    m_done = 1'b0;
  endtask

  // advance one clock and update the model from the inputs seen at that edge
  task automatic tick();
    bit l;
    bit e;
    logic [15:0] d;
    l = load;
    e = en;
    d = {8'h00, din};
    @(posedge clk);
    #1;
    if (l) begin
      m_val  = san_val(d, 2);
      m_busy = (m_val != 0);
      m_done = (m_val == 0);
    end else if (m_busy && e) begin
      m_val  = m_val - 1;
      m_busy = (m_val != 0);
      m_done = (m_val == 0);
    end else begin
      m_done = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [15:0] e;
    reset = 1'b1;
    #12;
    e = to_bcd(m_val);
    checks++;
    if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: Q=%h busy=%b done=%b, want Q=00 busy=0 done=0", q, busy, done);
    end
    @(negedge clk);
    reset = 1'b0;
    load = 1'b0; en = 1'b1;
    tick();
    e = to_bcd(m_val);
    checks++;
    if (q !== e[7:0] || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_en_ignored: Q=%h busy=%b done=%b, want Q=%h busy=0 done=0", q, busy, done, e[7:0]);
    end
  endtask

  task automatic test_reset_mid_count();
    load = 1'b1; en = 1'b1; din = 8'h25;
    tick();
    load = 1'b0;
    repeat (5) tick();
    checks++;
    if (q !== 8'h20 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midcount_pre: Q=%h busy=%b, want Q=20 busy=1", q, busy);
    end
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    checks++;
    if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: Q=%h busy=%b done=%b, want Q=00 busy=0 done=0", q, busy, done);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_idle: cycle %0d Q=%h busy=%b done=%b, want 00/0/0", i, q, busy, done);
      end
    end
  endtask

  task automatic test_full_countdown();
    logic [15:0] e;
    int done_cnt;
    int done_at;
    done_cnt = 0;
    done_at  = -1;
    load = 1'b1; en = 1'b1; din = 8'h12;
    tick();
    load = 1'b0;
    checks++;
    if (q !== 8'h12 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL countdown_load: Q=%h busy=%b done=%b, want 12/1/0", q, busy, done);
    end
    for (int i = 1; i <= 14; i++) begin
      tick();
      e = to_bcd(m_val);
      if (done === 1'b1) begin
        done_cnt++;
        done_at = i;
      end
      checks++;
      if (q !== e[7:0] || busy !== m_busy || done !== m_done) begin
        errors++;
        $display("FAIL countdown_step: edge %0d Q=%h busy=%b done=%b, want %h/%b/%b", i, q, busy, done, e[7:0], m_busy, m_done);
      end
    end
    checks++;
    if (done_cnt != 1 || done_at != 12) begin
      errors++;
      $display("FAIL countdown_done_pulse: count=%0d at edge %0d, want 1 at edge 12", done_cnt, done_at);
    end
  endtask

  task automatic test_enable_gating();
    logic [7:0] exp_q [5] = '{8'h02, 8'h02, 8'h02, 8'h01, 8'h00};
    bit         pat   [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    load = 1'b1; en = 1'b0; din = 8'h03;
    tick();
    load = 1'b0;
    checks++;
    if (q !== 8'h03) begin
      errors++;
      $display("FAIL gating_load: Q=%h want 03", q);
    end
    for (int i = 0; i < 5; i++) begin
      en = pat[i];
      tick();
      checks++;
      if (q !== exp_q[i] || done !== (i == 4) || q !== 8'(to_bcd(m_val))) begin
        errors++;
        $display("FAIL gating_step: step %0d Q=%h done=%b, want Q=%h done=%b", i, q, done, exp_q[i], (i == 4));
      end
    end
    en = 1'b0;
    tick();
  endtask

  task automatic test_load_priority();
    load = 1'b1; en = 1'b1; din = 8'h09;
    tick();
    load = 1'b0;
    repeat (2) tick();
    checks++;
    if (q !== 8'h07) begin
      errors++;
      $display("FAIL prio_setup: Q=%h want 07", q);
    end
    load = 1'b1; en = 1'b1; din = 8'h40;
    tick();
    checks++;
    if (q !== 8'h40 || busy !== 1'b1 || m_val != 40) begin
      errors++;
      $display("FAIL prio_reload: Q=%h busy=%b, want 40/1", q, busy);
    end
    load = 1'b0;
    tick();
    checks++;
    if (q !== 8'h39 || busy !== 1'b1) begin
      errors++;
      $display("FAIL prio_borrow: Q=%h busy=%b, want 39/1", q, busy);
    end
    en = 1'b0;
    load = 1'b1; din = 8'h00;
    tick();
    load = 1'b0;
    tick();
  endtask

  task automatic test_presets();
    load = 1'b1; en = 1'b1; din = 8'h00;
    tick();
    load = 1'b0;
    checks++;
    if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL zero_preset: Q=%h busy=%b done=%b, want 00/0/1", q, busy, done);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL zero_preset_idle: busy=%b done=%b, want 0/0", busy, done);
    end
    load = 1'b1; en = 1'b0; din = 8'hA3;
    tick();
    checks++;
    if (q !== 8'h93 || busy !== 1'b1) begin
      errors++;
      $display("FAIL invalid_preset: Q=%h busy=%b, want 93/1", q, busy);
    end
    din = 8'h01; en = 1'b1;
    tick();
    load = 1'b0;
    tick();
    checks++;
    if (q !== 8'h00 || done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_reach_done: Q=%h done=%b, want 00/1", q, done);
    end
    load = 1'b1; din = 8'h02;
    tick();
    load = 1'b0; en = 1'b0;
    checks++;
    if (q !== 8'h02 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_restart: Q=%h busy=%b done=%b, want 02/1/0", q, busy, done);
    end
  endtask

  task automatic test_random();
    logic [15:0] e;
    int bad;
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      load = ($urandom_range(0, 7) == 0);
      en   = ($urandom_range(0, 3) != 0);
      din  = 8'($urandom);
      if ($urandom_range(0, 3) == 0) din = {4'($urandom_range(0, 2)), 4'($urandom)};
      tick();
      e = to_bcd(m_val);
      checks++;
      if (q !== e[7:0] || busy !== m_busy || done !== m_done) begin
        errors++;
        bad++;
        if (bad < 10)
          $display("FAIL random: iter %0d Q=%h busy=%b done=%b, want %h/%b/%b", i, q, busy, done, e[7:0], m_busy, m_done);
      end
    end
    load = 1'b0; en = 1'b0;
  endtask

  task automatic test_ndig3();
    logic [15:0] e;
    int done_cnt;
    done_cnt = 0;
    load3 = 1'b1; en3 = 1'b1; din3 = 12'h100;
    tick();
    load3 = 1'b0;
    checks++;
    if (q3 !== 12'h100 || busy3 !== 1'b1) begin
      errors++;
      $display("FAIL ndig3_load: Q=%h busy=%b, want 100/1", q3, busy3);
    end
    for (int i = 1; i <= 102; i++) begin
      tick();
      e = (i <= 100) ? to_bcd(100 - i) : to_bcd(0);
      if (done3 === 1'b1) done_cnt++;
      checks++;
      if (q3 !== e[11:0] || busy3 !== (i < 100) || done3 !== (i == 100)) begin
        errors++;
        $display("FAIL ndig3_step: edge %0d Q=%h busy=%b done=%b, want %h/%b/%b", i, q3, busy3, done3, e[11:0], (i < 100), (i == 100));
      end
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL ndig3_done_count: %0d pulses, want 1", done_cnt);
    end
    en3 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_reset_mid_count();
    test_full_countdown();
    test_enable_gating();
    test_load_priority();
    test_presets();
    test_random();
    test_ndig3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
